decode_stage: RTL and testbench

- Registered, parametrised RV32IM decode stage between fetch and execute.
- Buffers fetched instructions in a small instruction queue and decodes the head entry.
- Produces a registered decoded packet with a valid/ready handshake, sign-extended immediate, register indices and illegal-instruction detection.
- Supports branch-redirect flush and optional M-extension.

---
 rtl/decode_pkg.sv | 83 ++++++++
 rtl/decode_stage_field_decode.sv | 149 ++++++++++++++
 rtl/decode_stage.sv | 103 ++++++++++
 tb/tb_decode_stage.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared types, opcodes and immediate generation for the RV32IM decode stage.
package decode_pkg;

  localparam int unsigned XLEN_MAX = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000, ALU_SLL  = 4'b0001, ALU_SLT  = 4'b0010, ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100, ALU_SRL  = 4'b0101, ALU_OR   = 4'b0110, ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000, ALU_BGE  = 4'b1001, ALU_BGEU = 4'b1010, ALU_SRA  = 4'b1101
  } alu_fn_e;

  typedef enum logic [2:0] {
    FN_ALU = 3'b000, FN_PC4 = 3'b001, FN_MULDIV = 3'b010,
    FN_IMM = 3'b011, FN_AUIPC = 3'b100, FN_LOAD = 3'b111
  } fn_e;

  typedef enum logic [3:0] {
    MEM_NONE = 4'b0000, MEM_SW = 4'b1111, MEM_SH = 4'b1011, MEM_SB = 4'b1101,
    MEM_LW   = 4'b0111, MEM_LH = 4'b0011, MEM_LHU = 4'b0010, MEM_LB = 4'b0101,
    MEM_LBU  = 4'b0100
  } mem_op_e;

  typedef enum logic [2:0] {
    MD_MUL = 3'b000, MD_MULH = 3'b001, MD_MULHSU = 3'b010, MD_MULHU = 3'b011,
    MD_DIV = 3'b101, MD_DIVU = 3'b100, MD_REM = 3'b111, MD_REMU = 3'b110
  } muldiv_op_e;

  typedef enum logic [1:0] {
    BSEL_REG = 2'b00, BSEL_IMM = 2'b01, BSEL_SHAMT = 2'b10
  } bsel_e;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SH
  } imm_fmt_e;

  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [31:0]         imm;
    bsel_e               b_sel;
    logic                we;
    fn_e                 fn;
    alu_fn_e             alu_fn;
    mem_op_e             mem_op;
    muldiv_op_e          muldiv_op;
    logic                j;
    logic                jr;
    logic                btype;
    logic                bneq;
    logic                lui;
    logic                auipc;
    logic                illegal;
  } decode_pkt_t;

  // Shift immediates carry only the zero-extended shamt.
  function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_fmt_e fmt);
    logic [31:0] imm;
    imm = '0;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_SH:  imm = {27'b0, instr[24:20]};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_stage_field_decode.sv
// Combinational RV32IM field decoder: raw instruction to decoded packet (pc left zero).
module instr_field_decode
  import decode_pkg::*;
#(
  parameter bit EN_M = 1'b1
) (
  input  logic [31:0]  i_instr,
  output decode_pkt_t  o_pkt_c
);

  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic        w_legal;
  imm_fmt_e    w_fmt;
  decode_pkt_t w_pkt;

  assign w_opc = i_instr[6:0];
  assign w_f3  = i_instr[14:12];
  assign w_f7  = i_instr[31:25];

  always_comb begin
    w_pkt     = '0;
    w_fmt     = IMM_NONE;
    w_legal   = 1'b0;
    w_pkt.rs1 = i_instr[19:15];
    w_pkt.rs2 = i_instr[24:20];
    w_pkt.rd  = i_instr[11:7];
    case (w_opc)
      OPC_OP: begin
        w_pkt.we = 1'b1;
        if (w_f7 == 7'b0000000) begin
          w_legal      = 1'b1;
          w_pkt.alu_fn = alu_fn_e'({1'b0, w_f3});
        end else if (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)) begin
          w_legal      = 1'b1;
          w_pkt.alu_fn = alu_fn_e'({1'b1, w_f3});
        end else if (w_f7 == 7'b0000001 && EN_M) begin
          w_legal         = 1'b1;
          w_pkt.fn        = FN_MULDIV;
          w_pkt.muldiv_op = muldiv_op_e'({w_f3[2], w_f3[1], w_f3[0] ^ w_f3[2]});
        end
      end
      OPC_OP_IMM: begin
        w_pkt.we     = 1'b1;
        w_pkt.b_sel  = BSEL_IMM;
        w_pkt.alu_fn = alu_fn_e'({1'b0, w_f3});
        w_fmt        = IMM_I;
        w_legal      = 1'b1;
        if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
          w_pkt.b_sel = BSEL_SHAMT;
          w_fmt       = IMM_SH;
          w_legal     = (w_f7 == 7'b0000000) || (w_f3 == 3'b101 && w_f7 == 7'b0100000);
          if (w_f7[5]) w_pkt.alu_fn = ALU_SRA;
        end
      end
      OPC_LOAD: begin
        w_pkt.we    = 1'b1;
        w_pkt.fn    = FN_LOAD;
        w_pkt.b_sel = BSEL_IMM;
        w_fmt       = IMM_I;
        w_legal     = 1'b1;
        case (w_f3)
          3'b000:  w_pkt.mem_op = MEM_LB;
          3'b001:  w_pkt.mem_op = MEM_LH;
          3'b010:  w_pkt.mem_op = MEM_LW;
          3'b100:  w_pkt.mem_op = MEM_LBU;
          3'b101:  w_pkt.mem_op = MEM_LHU;
          default: w_legal      = 1'b0;
        endcase
      end
      OPC_STORE: begin
        w_pkt.b_sel = BSEL_IMM;
        w_fmt       = IMM_S;
        w_legal     = 1'b1;
        case (w_f3)
          3'b000:  w_pkt.mem_op = MEM_SB;
          3'b001:  w_pkt.mem_op = MEM_SH;
          3'b010:  w_pkt.mem_op = MEM_SW;
          default: w_legal      = 1'b0;
        endcase
      end
      OPC_BRANCH: begin
        w_pkt.btype = 1'b1;
        w_fmt       = IMM_B;
        w_legal     = 1'b1;
        case (w_f3)
          3'b000:  w_pkt.alu_fn = ALU_SUB;
          3'b001: begin
            w_pkt.alu_fn = ALU_SUB;
            w_pkt.bneq   = 1'b1;
          end
          3'b100:  w_pkt.alu_fn = ALU_SLT;
          3'b101:  w_pkt.alu_fn = ALU_BGE;
          3'b110:  w_pkt.alu_fn = ALU_SLTU;
          3'b111:  w_pkt.alu_fn = ALU_BGEU;
          default: w_legal      = 1'b0;
        endcase
      end
      OPC_JAL: begin
        w_pkt.j  = 1'b1;
        w_pkt.fn = FN_PC4;
        w_pkt.we = 1'b1;
        w_fmt    = IMM_J;
        w_legal  = 1'b1;
      end
      OPC_JALR: begin
        w_pkt.jr    = 1'b1;
        w_pkt.fn    = FN_PC4;
        w_pkt.we    = 1'b1;
        w_pkt.b_sel = BSEL_IMM;
        w_fmt       = IMM_I;
        w_legal     = (w_f3 == 3'b000);
      end
      OPC_LUI: begin
        w_pkt.lui = 1'b1;
        w_pkt.fn  = FN_IMM;
        w_pkt.we  = 1'b1;
        w_fmt     = IMM_U;
        w_legal   = 1'b1;
      end
      OPC_AUIPC: begin
        w_pkt.auipc = 1'b1;
        w_pkt.fn    = FN_AUIPC;
        w_pkt.we    = 1'b1;
        w_fmt       = IMM_U;
        w_legal     = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
    w_pkt.imm = imm_gen(i_instr, w_fmt);

    // All-zero word is a pipeline bubble, not an illegal instruction.
    if (i_instr == 32'h0) begin
      w_pkt = '0;
    end else if (!w_legal) begin
      w_pkt.illegal = 1'b1;
      w_pkt.we      = 1'b0;
      w_pkt.mem_op  = MEM_NONE;
      w_pkt.j       = 1'b0;
      w_pkt.jr      = 1'b0;
      w_pkt.btype   = 1'b0;
    end
    if (w_pkt.rd == 5'd0) w_pkt.we = 1'b0;
  end

  assign o_pkt_c = w_pkt;

endmodule

// File: rtl/decode_stage.sv
// Decode stage: instruction queue feeding a registered decoded-packet output with valid/ready.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned IQ_DEPTH = 4,
  parameter bit          EN_M     = 1'b1
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output decode_pkt_t     dec_o
);

  localparam int unsigned PTR_W = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(IQ_DEPTH + 1);

  logic [31:0]      r_instr_q [IQ_DEPTH];
  logic [XLEN-1:0]  r_pc_q    [IQ_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_in_ready;
  logic             r_out_valid;
  decode_pkt_t      r_dec;
  decode_pkt_t      w_dec_raw;
  decode_pkt_t      w_dec;
  logic             w_push;
  logic             w_pop;

  assign w_push = in_valid & r_in_ready;
  assign w_pop  = (r_count != '0) & (~r_out_valid | out_ready);

  instr_field_decode #(
    .EN_M (EN_M)
  ) u_field_decode (
    .i_instr (r_instr_q[r_rd_ptr]),
    .o_pkt_c (w_dec_raw)
  );

  always_comb begin
    w_dec    = w_dec_raw;
    w_dec.pc = 32'(r_pc_q[r_rd_ptr]);
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Queue storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_instr_q[r_wr_ptr] <= in_instr;
      r_pc_q[r_wr_ptr]    <= in_pc;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_dec       <= '0;
    end else if (flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_dec       <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + PTR_W'(1);
        r_dec       <= w_dec;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt != CNT_W'(IQ_DEPTH));
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign dec_o     = r_dec;

endmodule

// File: tb/tb_decode_stage.sv
// Randomised bench for decode_stage against a transaction-level queue model and a table-driven decoder.
module tb_decode_stage;
  import decode_pkg::*;

  localparam int unsigned IQ_DEPTH = 4;

  logic        clk = 1'b0;
  logic        nrst;
  logic        flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;
  logic        in_ready, out_valid;
  decode_pkt_t dec_o;

  logic        nm_flush, nm_in_valid, nm_out_ready;
  logic [31:0] nm_in_instr, nm_in_pc;
  logic        nm_in_ready, nm_out_valid;
  decode_pkt_t nm_dec;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .IQ_DEPTH(IQ_DEPTH), .EN_M(1'b1)) u_dut (
    .clk(clk), .nrst(nrst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready), .dec_o(dec_o)
  );

  decode_stage #(.XLEN(32), .IQ_DEPTH(IQ_DEPTH), .EN_M(1'b0)) u_dut_nm (
    .clk(clk), .nrst(nrst), .flush(nm_flush), .in_valid(nm_in_valid), .in_ready(nm_in_ready),
    .in_instr(nm_in_instr), .in_pc(nm_in_pc), .out_valid(nm_out_valid), .out_ready(nm_out_ready),
    .dec_o(nm_dec)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } item_t;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  item_t       mq [$];
  item_t       m_out;
  bit          m_ov = 1'b0;
  bit          m_rdy = 1'b0;
  logic [31:0] next_pc = 32'h0000_1000;

  muldiv_op_e md_tab [8] = '{MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  mem_op_e    ld_tab [8] = '{MEM_LB, MEM_LH, MEM_LW, MEM_NONE, MEM_LBU, MEM_LHU, MEM_NONE, MEM_NONE};
  mem_op_e    st_tab [8] = '{MEM_SB, MEM_SH, MEM_SW, MEM_NONE, MEM_NONE, MEM_NONE, MEM_NONE, MEM_NONE};
  alu_fn_e    br_tab [8] = '{ALU_SUB, ALU_SUB, ALU_ADD, ALU_ADD, ALU_SLT, ALU_BGE, ALU_SLTU, ALU_BGEU};
  logic [6:0] opc_tab [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17};

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, act, exp);
  endtask

  // Expected decode derived from instruction-class tables and integer arithmetic.
  function automatic decode_pkt_t ref_decode(input logic [31:0] ins, input logic [31:0] pc, input bit en_m);
    decode_pkt_t p;
    int unsigned u, opc, f3, f7;
    int          s12, s7, s1;
    bit          ok;
    p    = '0;
    p.pc = pc;
    if (ins == 32'h0) return p;
    u   = ins;
    opc = u % 128;
    f3  = (u >> 12) % 8;
    f7  = u >> 25;
    s12 = int'(ins) >>> 20;
    s7  = int'(ins) >>> 25;
    s1  = int'(ins) >>> 31;
    p.rd  = 5'((u >> 7) % 32);
    p.rs1 = 5'((u >> 15) % 32);
    p.rs2 = 5'((u >> 20) % 32);
    ok = 1'b0;
    case (opc)
      'h33: begin
        p.we = 1'b1;
        if (f7 == 0) begin ok = 1'b1; p.alu_fn = alu_fn_e'(4'(f3)); end
        else if (f7 == 'h20 && (f3 == 0 || f3 == 5)) begin ok = 1'b1; p.alu_fn = alu_fn_e'(4'(f3 + 8)); end
        else if (f7 == 1 && en_m) begin ok = 1'b1; p.fn = FN_MULDIV; p.muldiv_op = md_tab[f3]; end
      end
      'h13: begin
        p.we = 1'b1; p.b_sel = BSEL_IMM; p.alu_fn = alu_fn_e'(4'(f3)); p.imm = 32'(s12); ok = 1'b1;
        if (f3 == 1 || f3 == 5) begin
          p.b_sel = BSEL_SHAMT;
          p.imm   = 32'((u >> 20) % 32);
          ok      = (f7 == 0) || (f3 == 5 && f7 == 'h20);
          if (f7 == 'h20) p.alu_fn = ALU_SRA;
        end
      end
      'h03: begin
        p.we = 1'b1; p.fn = FN_LOAD; p.b_sel = BSEL_IMM; p.imm = 32'(s12);
        p.mem_op = ld_tab[f3]; ok = (ld_tab[f3] != MEM_NONE);
      end
      'h23: begin
        p.b_sel = BSEL_IMM; p.imm = 32'(s7 * 32 + int'((u >> 7) % 32));
        p.mem_op = st_tab[f3]; ok = (st_tab[f3] != MEM_NONE);
      end
      'h63: begin
        p.btype = 1'b1; p.alu_fn = br_tab[f3]; p.bneq = (f3 == 1); ok = (f3 != 2 && f3 != 3);
        p.imm = 32'(s1 * 4096 + int'(((u >> 7) % 2) * 2048 + ((u >> 25) % 64) * 32 + ((u >> 8) % 16) * 2));
      end
      'h6f: begin
        p.j = 1'b1; p.fn = FN_PC4; p.we = 1'b1; ok = 1'b1;
        p.imm = 32'(s1 * 1048576 + int'(((u >> 12) % 256) * 4096 + ((u >> 20) % 2) * 2048 + ((u >> 21) % 1024) * 2));
      end
      'h67: begin
        p.jr = 1'b1; p.fn = FN_PC4; p.we = 1'b1; p.b_sel = BSEL_IMM; p.imm = 32'(s12); ok = (f3 == 0);
      end
      'h37: begin p.lui = 1'b1; p.fn = FN_IMM; p.we = 1'b1; p.imm = 32'(u - u % 4096); ok = 1'b1; end
      'h17: begin p.auipc = 1'b1; p.fn = FN_AUIPC; p.we = 1'b1; p.imm = 32'(u - u % 4096); ok = 1'b1; end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      p.illegal = 1'b1; p.we = 1'b0; p.mem_op = MEM_NONE; p.j = 1'b0; p.jr = 1'b0; p.btype = 1'b0;
    end
    if (p.rd == 5'd0) p.we = 1'b0;
    return p;
  endfunction

  // For illegal words only illegal/we/mem_op/j/jr/btype and pc are defined.
  function automatic decode_pkt_t mask_pkt(input decode_pkt_t p, input bit ill);
    decode_pkt_t m;
    m = p;
    if (ill) begin
      m.rs1 = '0; m.rs2 = '0; m.rd = '0; m.imm = '0; m.b_sel = BSEL_REG; m.fn = FN_ALU;
      m.alu_fn = ALU_ADD; m.muldiv_op = MD_MUL; m.bneq = 1'b0; m.lui = 1'b0; m.auipc = 1'b0;
    end
    return m;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int unsigned k;
    r = $urandom();
    k = $urandom_range(0, 11);
    if (k == 11) return 32'h0;
    if (k >= 9) return r;
    r[6:0] = opc_tab[k];
    case ($urandom_range(0, 3))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      2: r[31:25] = 7'h01;
      default: r[31:25] = r[31:25];
    endcase
    return r;
  endfunction

  // One clock: drive at negedge, advance the model at posedge, compare 1 time unit later.
  task automatic step(input bit v, input logic [31:0] ins, input bit ordy, input bit fl);
    bit          push, pop;
    item_t       it;
    decode_pkt_t exp;
    @(negedge clk);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = next_pc;
    out_ready = ordy;
    flush     = fl;
    push = v && m_rdy;
    pop  = (mq.size() != 0) && (!m_ov || ordy);
    it.instr = ins;
    it.pc    = next_pc;
    @(posedge clk);
    if (fl) begin
      mq.delete();
      m_ov = 1'b0;
    end else begin
      if (pop) begin
        m_out = mq.pop_front();
        m_ov  = 1'b1;
      end else if (ordy) begin
        m_ov = 1'b0;
      end
      if (push) mq.push_back(it);
    end
    if (v) next_pc += 32'd4;
    m_rdy = (mq.size() < IQ_DEPTH);
    #1;
    chk("out_valid", 128'(out_valid), 128'(m_ov));
    chk("in_ready", 128'(in_ready), 128'(m_rdy));
    if (m_ov) begin
      exp = ref_decode(m_out.instr, m_out.pc, 1'b1);
      chk("dec_o", 128'(mask_pkt(dec_o, exp.illegal)), 128'(mask_pkt(exp, exp.illegal)));
    end
  endtask

  initial begin
    logic [31:0] first_pc;
    nrst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0; in_pc = '0;
    nm_flush = 1'b0; nm_in_valid = 1'b0; nm_out_ready = 1'b1; nm_in_instr = '0; nm_in_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_dec_o", 128'(dec_o), 128'(0));
    @(negedge clk);
    nrst = 1'b1;
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // addi x1,x0,5: visible two edges after being presented
    step(1'b1, 32'h0050_0093, 1'b1, 1'b0);
    chk("addi_lat_ov", 128'(out_valid), 128'(0));
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("addi_ov", 128'(out_valid), 128'(1));
    chk("addi_rd", 128'(dec_o.rd), 128'(5'd1));
    chk("addi_imm", 128'(dec_o.imm), 128'(32'd5));
    chk("addi_alu", 128'(dec_o.alu_fn), 128'(4'b0000));
    chk("addi_bsel", 128'(dec_o.b_sel), 128'(2'b01));
    chk("addi_we", 128'(dec_o.we), 128'(1));
    chk("addi_fn", 128'(dec_o.fn), 128'(3'b000));
    chk("addi_ill", 128'(dec_o.illegal), 128'(0));

    // mul x2,x1,x2 on both configurations
    fork
      begin
        step(1'b1, 32'h0220_8133, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
      end
      begin
        @(negedge clk);
        nm_in_valid = 1'b1;
        nm_in_instr = 32'h0220_8133;
        @(negedge clk);
        nm_in_valid = 1'b0;
      end
    join
    chk("mul_fn", 128'(dec_o.fn), 128'(3'b010));
    chk("mul_op", 128'(dec_o.muldiv_op), 128'(3'b000));
    chk("mul_we", 128'(dec_o.we), 128'(1));
    chk("nom_ov", 128'(nm_out_valid), 128'(1));
    chk("nom_ill", 128'(nm_dec.illegal), 128'(1));
    chk("nom_we", 128'(nm_dec.we), 128'(0));

    // sw x2,8(x1)
    step(1'b1, 32'h0020_A423, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("sw_mem", 128'(dec_o.mem_op), 128'(4'b1111));
    chk("sw_imm", 128'(dec_o.imm), 128'(32'd8));
    chk("sw_bsel", 128'(dec_o.b_sel), 128'(2'b01));
    chk("sw_we", 128'(dec_o.we), 128'(0));
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Backpressure: five pushes fill output plus all queue entries
    first_pc = next_pc;
    for (int i = 0; i < 5; i++) step(1'b1, rand_instr(), 1'b0, 1'b0);
    chk("bp_full_rdy", 128'(in_ready), 128'(0));
    for (int i = 0; i < 2; i++) step(1'b1, rand_instr(), 1'b0, 1'b0);
    chk("bp_hold_pc", 128'(dec_o.pc), 128'(first_pc));
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("bp_rdy_after_pop", 128'(in_ready), 128'(1));
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush with one in output, three queued and a same-cycle push
    for (int i = 0; i < 4; i++) step(1'b1, rand_instr(), 1'b0, 1'b0);
    step(1'b1, 32'h0050_0093, 1'b1, 1'b1);
    chk("flush_ov", 128'(out_valid), 128'(0));
    chk("flush_rdy", 128'(in_ready), 128'(1));
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("flush_empty", 128'(out_valid), 128'(0));

    // Random traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) < 7, rand_instr(), $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset between edges
    for (int i = 0; i < 3; i++) step(1'b1, rand_instr(), 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 nrst = 1'b0;
    #1;
    chk("mid_rst_ov", 128'(out_valid), 128'(0));
    chk("mid_rst_dec", 128'(dec_o), 128'(0));
    chk("mid_rst_rdy", 128'(in_ready), 128'(0));
    mq.delete();
    m_ov  = 1'b0;
    m_rdy = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Undefined opcode
    step(1'b1, 32'h0000_007F, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("ill7f_ill", 128'(dec_o.illegal), 128'(1));
    chk("ill7f_we", 128'(dec_o.we), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
